// File: rtl/gray_pkg.sv
// Shared types, default width and Gray/binary conversion helpers for the
// Gray-code source and any downstream checkers.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_W_MAX     = 32;

  typedef enum logic {IDLE, EMIT} gsrc_state_t;

  // Operands are zero-extended to GRAY_W_MAX; the zero upper bits do not
  // disturb either conversion, so callers slice the low WIDTH bits.
  function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    logic                  acc;
    b   = '0;
    acc = 1'b0;
    for (int unsigned i = 0; i < GRAY_W_MAX; i++) begin
      acc                 = acc ^ g[GRAY_W_MAX-1-i];
      b[GRAY_W_MAX-1-i]   = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter: prefix XOR from the MSB down.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      acc              = acc ^ gray[WIDTH-1-i];
      bin[WIDTH-1-i]   = acc;
    end
  end

endmodule

// File: rtl/gray_code_source.sv
// Clocked Gray-code stimulus source: binary counter presented as Gray code
// over a valid/ready handshake, with up/down stepping, Gray load and wrap pulse.
module gray_code_source
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g_out,
  output logic             g_valid,
  input  logic             g_ready,
  output logic             wrap
);

  gsrc_state_t      state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] load_bin;
  logic             wrap_d;
  logic             hs;

  gray_to_bin #(.WIDTH(WIDTH)) u_load_conv (
    .gray (load_val),
    .bin  (load_bin)
  );

  assign g_valid = (state_q == EMIT);
  assign hs      = g_valid && g_ready;

  // load pre-empts everything, including a same-cycle handshake
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    wrap_d  = 1'b0;
    if (load) begin
      bin_d   = load_bin;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (en) state_d = EMIT;
        EMIT: begin
          if (hs) begin
            bin_d   = up_dn ? bin_q + 1'b1 : bin_q - 1'b1;
            wrap_d  = up_dn ? (&bin_q) : ~(|bin_q);
            state_d = en ? EMIT : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      g_out   <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      g_out   <= bin_d ^ (bin_d >> 1);
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_gray_code_source.sv
// Scoreboard bench for gray_code_source: a driver predicts each cycle's
// outputs from an integer-count model and a monitor compares after each edge.
module tb_gray_code_source;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] g_out;
  logic         g_valid;
  logic         g_ready = 1'b0;
  logic         wrap;

  gray_code_source #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .g_out    (g_out),
    .g_valid  (g_valid),
    .g_ready  (g_ready),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic         v;
    logic         w;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   hs_seen = 0;
  bit   done = 1'b0;

  // reference model state: plain integer count and a "presenting" flag
  int   cnt = 0;
  bit   vld = 1'b0;
  bit   wrp = 1'b0;

  function automatic logic [W-1:0] gray_of(input int n);
    int g;
    g = n ^ (n >> 1);
    return g[W-1:0];
  endfunction

  // invert Gray by exhaustive search rather than by XOR-folding
  function automatic int bin_of(input logic [W-1:0] g);
    for (int b = 0; b < N; b++)
      if (gray_of(b) == g) return b;
    return 0;
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit ld,
                      input logic [W-1:0] lv, input bit rdy);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; up_dn = u; load = ld; load_val = lv; g_ready = rdy;
    if (!r) begin
      cnt = 0; vld = 0; wrp = 0;
    end else if (ld) begin
      cnt = bin_of(lv); vld = 0; wrp = 0;
    end else if (vld && rdy) begin
      if (u) begin
        wrp = (cnt == N - 1);
        cnt = (cnt + 1) % N;
      end else begin
        wrp = (cnt == 0);
        cnt = (cnt + N - 1) % N;
      end
      vld = e;
      hs_seen++;
    end else begin
      wrp = 0;
      if (!vld && e) vld = 1;
    end
    x.g = gray_of(cnt);
    x.v = vld;
    x.w = wrp;
    q.push_back(x);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
  endtask

  initial begin : monitor
    exp_t x;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        cmp("g_out",   int'(g_out),   int'(x.g));
        cmp("g_valid", int'(g_valid), int'(x.v));
        cmp("wrap",    int'(wrap),    int'(x.w));
      end
    end
  end

  initial begin : driver
    // 1. reset with en held high
    step(0, 1, 1, 0, 4'b0000, 0);
    step(0, 1, 1, 0, 4'b0000, 0);
    // 2. count up through a full wrap
    for (int i = 0; i < 19; i++) step(1, 1, 1, 0, 4'b0000, 1);
    // 3. back-pressure on 0011
    step(1, 0, 1, 1, 4'b0011, 0);
    step(1, 1, 1, 0, 4'b0000, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 4'b0000, 0);
    step(1, 1, 1, 0, 4'b0000, 1);
    step(1, 0, 1, 0, 4'b0000, 0);
    step(1, 0, 1, 0, 4'b0000, 1);
    // 4. load 0000, count down across the wrap, then load during a handshake
    step(1, 1, 0, 1, 4'b0000, 0);
    step(1, 1, 0, 0, 4'b0000, 0);
    step(1, 1, 0, 0, 4'b0000, 1);
    step(1, 1, 0, 0, 4'b0000, 0);
    step(1, 1, 1, 1, 4'b0101, 1);
    step(1, 1, 1, 0, 4'b0000, 0);
    step(1, 1, 1, 0, 4'b0000, 0);
    // 5. en dropped while holding 0110
    step(1, 0, 1, 1, 4'b0110, 0);
    step(1, 1, 1, 0, 4'b0000, 0);
    step(1, 0, 1, 0, 4'b0000, 0);
    step(1, 0, 1, 0, 4'b0000, 0);
    step(1, 0, 1, 0, 4'b0000, 1);
    step(1, 0, 1, 0, 4'b0000, 1);
    // 6. reset while a handshake is pending on 0110
    step(1, 0, 1, 1, 4'b0110, 0);
    step(1, 1, 1, 0, 4'b0000, 0);
    step(0, 1, 1, 1, 4'b1111, 1);
    step(1, 0, 1, 0, 4'b0000, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 11) == 0),
           W'($urandom_range(0, N - 1)),
           ($urandom_range(0, 2) != 0));
    end
    step(1, 0, 1, 0, 4'b0000, 0);
    repeat (2) @(posedge clk);
    #2;
    cmp("queue_drained", q.size(), 0);
    checks++;
    if (hs_seen > 20) passes++;
    else $display("FAIL hs_count: got %0d, expected more than 20", hs_seen);
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
